sfm_tcdm_responder: RTL and testbench

//   Single-port TCDM responder: slave end of the hci_core request/response protocol driven by the

---
 rtl/sfm_tcdm_responder.sv | 93 +++++++++
 tb/tb_sfm_tcdm_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sfm_tcdm_responder.sv
// Single-port TCDM responder: grants hci_core requests, performs byte-enabled word writes and
// returns read data through a fixed-latency response pipeline.
module sfm_tcdm_responder #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int LATENCY    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    stall_i,
    input  logic                    tcdm_req_i,
    output logic                    tcdm_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
    input  logic                    tcdm_wen_i,
    input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
    output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
    output logic                    tcdm_r_valid_o,
    output logic                    oor_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BE_W);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int HI_SH = OFS + IDX_W;

    logic                  w_gnt;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_oor;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rdWord;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [LATENCY-1:0]    r_pipeValid;
    logic [DATA_WIDTH-1:0] r_pipeData [LATENCY];
    logic                  r_oor;

    assign w_gnt    = tcdm_req_i & ~stall_i & ~rst_i;
    assign w_rd     = w_gnt & tcdm_wen_i;
    assign w_wr     = w_gnt & ~tcdm_wen_i;
    assign w_idx    = tcdm_add_i[OFS +: IDX_W];
    assign w_oor    = |(tcdm_add_i >> HI_SH);
    assign w_rdWord = r_mem[w_idx];

    // Storage is intentionally not reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int k = 0; k < BE_W; k++) begin
                if (tcdm_be_i[k]) begin
                    r_mem[w_idx][k*8 +: 8] <= tcdm_data_i[k*8 +: 8];
                end
            end
        end
    end

    // Data stages only advance behind a live valid, so the output word holds between responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pipeValid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pipeData[i] <= '0;
            end
        end else begin
            r_pipeValid[0] <= w_rd & ~clear_i;
            if (w_rd && !clear_i) begin
                r_pipeData[0] <= w_rdWord;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1] & ~clear_i;
                if (r_pipeValid[i-1] && !clear_i) begin
                    r_pipeData[i] <= r_pipeData[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_oor <= 1'b0;
        end else if (w_gnt && w_oor) begin
            r_oor <= 1'b1;
        end
    end

    assign tcdm_gnt_o     = w_gnt;
    assign tcdm_r_valid_o = r_pipeValid[LATENCY-1];
    assign tcdm_r_data_o  = r_pipeData[LATENCY-1];
    assign oor_o          = r_oor;

endmodule

// File: tb/tb_sfm_tcdm_responder.sv
// Directed bench for sfm_tcdm_responder: three instances (LATENCY 1, 2, 3) share one stimulus
// stream; a vector table covers single-cycle behaviour, hand sequences cover pipeline corners.
module tb_sfm_tcdm_responder;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          stall;
    logic          req;
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;

    logic          gnt1, gnt2, gnt3;
    logic          valid1, valid2, valid3;
    logic [DW-1:0] rdata1, rdata2, rdata3;
    logic          oor1, oor2, oor3;

    int testCount = 0;
    int failCount = 0;

    sfm_tcdm_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(64), .LATENCY(1)) u1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .stall_i(stall),
        .tcdm_req_i(req), .tcdm_gnt_o(gnt1), .tcdm_add_i(add), .tcdm_wen_i(wen),
        .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rdata1),
        .tcdm_r_valid_o(valid1), .oor_o(oor1));

    sfm_tcdm_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(64), .LATENCY(2)) u2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .stall_i(stall),
        .tcdm_req_i(req), .tcdm_gnt_o(gnt2), .tcdm_add_i(add), .tcdm_wen_i(wen),
        .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rdata2),
        .tcdm_r_valid_o(valid2), .oor_o(oor2));

    sfm_tcdm_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(64), .LATENCY(3)) u3 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .stall_i(stall),
        .tcdm_req_i(req), .tcdm_gnt_o(gnt3), .tcdm_add_i(add), .tcdm_wen_i(wen),
        .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rdata3),
        .tcdm_r_valid_o(valid3), .oor_o(oor3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic          stall;
        logic          wen;
        logic [AW-1:0] add;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
        logic          expGnt;
        logic          expValid;
        logic [DW-1:0] expData;
        logic          expOor;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    localparam logic [DW-1:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] PART = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000;
    localparam logic [DW-1:0] DE   = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [DW-1:0] DC   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [DW-1:0] DF   = 128'h55AA55AA_0F0F0F0F_F0F0F0F0_AA55AA55;

    function automatic logic [DW-1:0] seqWord(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + i;
        return {w, w, w, w};
    endfunction

    // Drives one cycle's inputs just after the falling edge.
    task automatic applyStimulus(input logic r, input logic s, input logic c, input logic we,
                                 input logic [AW-1:0] a, input logic [BW-1:0] b,
                                 input logic [DW-1:0] d);
        @(negedge clk);
        req   = r;
        stall = s;
        clear = c;
        wen   = we;
        add   = a;
        be    = b;
        wdata = d;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h30,  16'hFFFF, D1,   1'b1, 1'b0, '0,   1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h30,  16'h0000, '0,   1'b1, 1'b1, D1,   1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h30,  16'h0000, '0,   1'b0, 1'b0, D1,   1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h50,  16'hFFFF, ONES, 1'b1, 1'b0, D1,   1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h50,  16'h000F, '0,   1'b1, 1'b0, D1,   1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h50,  16'h0000, '0,   1'b1, 1'b1, PART, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h50,  16'h0000, '0,   1'b1, 1'b0, PART, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h5F,  16'h0000, '0,   1'b1, 1'b1, PART, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h70,  16'hFFFF, DE,   1'b0, 1'b0, PART, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h70,  16'hFFFF, DE,   1'b0, 1'b0, PART, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h70,  16'hFFFF, DE,   1'b0, 1'b0, PART, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h70,  16'hFFFF, DE,   1'b1, 1'b0, PART, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h70,  16'h0000, '0,   1'b1, 1'b1, DE,   1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h410, 16'hFFFF, DC,   1'b1, 1'b0, DE,   1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 32'h10,  16'h0000, '0,   1'b1, 1'b1, DC,   1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0,   16'h0000, '0,   1'b0, 1'b0, DC,   1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h410, 16'h0000, '0,   1'b0, 1'b0, DC,   1'b1};

        rst = 1'b1; clear = 1'b0; stall = 1'b0; req = 1'b1; add = '0; wen = 1'b1;
        be = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_gnt", {127'b0, gnt1}, 128'd0);
        checkOutput("reset_valid", {127'b0, valid1}, 128'd0);
        checkOutput("reset_rdata", rdata1, 128'd0);
        checkOutput("reset_oor", {127'b0, oor1}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;

        for (int v = 0; v < NV; v++) begin
            applyStimulus(vecs[v].req, vecs[v].stall, 1'b0, vecs[v].wen, vecs[v].add,
                          vecs[v].be, vecs[v].data);
            checkOutput($sformatf("vec%0d_gnt", v), {127'b0, gnt1}, {127'b0, vecs[v].expGnt});
            afterEdge();
            checkOutput($sformatf("vec%0d_valid", v), {127'b0, valid1},
                        {127'b0, vecs[v].expValid});
            checkOutput($sformatf("vec%0d_rdata", v), rdata1, vecs[v].expData);
            checkOutput($sformatf("vec%0d_oor", v), {127'b0, oor1}, {127'b0, vecs[v].expOor});
        end

        // Let the slower instances drain the reads from the table.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        checkOutput("l2_hold_before_clear", rdata2, DC);
        checkOutput("l2_oor_sticky", {127'b0, oor2}, 128'd1);

        // Read accepted, then clear next cycle: LATENCY=2 response must vanish.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h30, '0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
        afterEdge();
        checkOutput("clear_oor", {127'b0, oor2}, 128'd0);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("clear_l2_valid_c%0d", c), {127'b0, valid2}, 128'd0);
            checkOutput($sformatf("clear_l2_rdata_c%0d", c), rdata2, DC);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
        end

        // Clear with a same-cycle write commits it; a same-cycle read is dropped.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 16'hFFFF, DF);
        checkOutput("clear_wr_gnt", {127'b0, gnt1}, 128'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, '0, '0);
        afterEdge();
        checkOutput("clear_rd_dropped", {127'b0, valid1}, 128'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, '0, '0);
        afterEdge();
        checkOutput("clear_wr_valid", {127'b0, valid1}, 128'd1);
        checkOutput("clear_wr_data", rdata1, DF);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, AW'(i * 16), 16'hFFFF, seqWord(i));
        end

        // Back-to-back reads of idx 0..7 through the LATENCY=3 instance.
        for (int c = 0; c < 12; c++) begin
            if (c < 8) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, AW'(c * 16), '0, '0);
            else       applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
            afterEdge();
            if (c + 1 >= 3 && c + 1 < 11) begin
                checkOutput($sformatf("b2b_valid_c%0d", c + 1), {127'b0, valid3}, 128'd1);
                checkOutput($sformatf("b2b_data_c%0d", c + 1), rdata3, seqWord(c - 2));
            end else begin
                checkOutput($sformatf("b2b_valid_c%0d", c + 1), {127'b0, valid3}, 128'd0);
            end
        end

        // Reset while a LATENCY=3 read is in flight: response dropped, memory kept.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_gnt", {127'b0, gnt3}, 128'd0);
        afterEdge();
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            afterEdge();
            checkOutput($sformatf("rst_mid_valid_c%0d", c), {127'b0, valid3}, 128'd0);
        end
        checkOutput("rst_mid_rdata", rdata3, 128'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, '0, '0);
        afterEdge();
        checkOutput("rst_mem_kept", rdata1, seqWord(0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
